// File: rtl/spi_mem_responder_pkg.sv
// Shared definitions for the SPI word-memory responder: opcodes, frame field
// widths and the frame-decoder state encoding.
package spi_mem_responder_pkg;

    localparam logic [7:0] OPC_READ  = 8'h03;
    localparam logic [7:0] OPC_WRITE = 8'h02;

    localparam int OPC_BITS  = 8;
    localparam int ADDR_BITS = 24;
    localparam int WORD_BITS = 32;

    // Frame decoder states; the encoding is visible on the debug state output.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_ADDR    = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_WR_DATA = 3'd4,
        ST_IGNORE  = 3'd5
    } state_e;

    // True for the opcodes that lead into an address phase.
    function automatic logic opc_supported(input logic [7:0] opc);
        return (opc == OPC_READ) || (opc == OPC_WRITE);
    endfunction

endpackage

// File: rtl/spi_mem_responder_sync_edge.sv
// N-stage input synchronizer followed by an edge detector.  rise_o/fall_o are
// single-CLK pulses when the synchronized level changes.  RESET_VAL sets the
// idle level so no edge is reported when reset is released.
module spi_mem_responder_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              level;

    assign level = sync_q[STAGES-1];

    // Synchronizer chain plus one flop holding the previous synchronized sample.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= level;
        end
    end

    assign rise_o = level & ~prev_q;
    assign fall_o = ~level & prev_q;

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 target backed by a word memory.  Frames are an 8-bit opcode, a
// 24-bit byte address and then 32-bit words until cs_n rises.  READ (03h)
// streams words out on spi_miso, WRITE (02h) stores words; the word index
// auto-increments and wraps.  SPI pins are oversampled on CLK.
module spi_mem_responder
    import spi_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    input  logic       spi_cs_n,
    output logic       spi_miso,
    output logic       xfer_done,
    output logic       cmd_err,
    output logic [7:0] last_cmd,
    output logic [2:0] dbg_state_o
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [4:0] CMD_LAST  = 5'(OPC_BITS - 1);
    localparam logic [4:0] ADDR_LAST = 5'(ADDR_BITS - 1);
    localparam logic [4:0] WORD_LAST = 5'(WORD_BITS - 1);

    // Synchronized SPI pins and edge pulses
    logic sclk_rise, sclk_fall;
    logic cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic mosi_s;

    // Frame decoder state
    state_e               state_q, state_d;
    logic [4:0]           bit_cnt_q, bit_cnt_d;
    logic [WORD_BITS-1:0] shift_q, shift_d;
    logic [WORD_BITS-1:0] tx_q, tx_d;
    logic                 miso_q, miso_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [7:0]           last_cmd_q, last_cmd_d;
    logic                 xfer_done_q, xfer_done_d;
    logic                 cmd_err_q, cmd_err_d;
    logic                 load_q;

    // Memory ports
    logic [WORD_BITS-1:0] mem [DEPTH_WORDS];
    logic [WORD_BITS-1:0] rdata_q;
    logic                 mem_re;
    logic [IDX_W-1:0]     mem_ridx;
    logic                 mem_we;
    logic [WORD_BITS-1:0] shift_next;

    spi_mem_responder_sync_edge #(
        .STAGES   (SYNC_STAGES),
        .RESET_VAL(1'b0)
    ) u_sync_sclk (
        .clk_i (CLK),
        .rst_i (reset),
        .d_i   (spi_clk),
        .rise_o(sclk_rise),
        .fall_o(sclk_fall)
    );

    spi_mem_responder_sync_edge #(
        .STAGES   (SYNC_STAGES),
        .RESET_VAL(1'b1)
    ) u_sync_cs (
        .clk_i (CLK),
        .rst_i (reset),
        .d_i   (spi_cs_n),
        .rise_o(cs_rise),
        .fall_o(cs_fall)
    );

    // MOSI goes through the same number of stages as spi_clk so the sample
    // taken on a rise pulse is the bit the master presented at that edge.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) mosi_sync_q <= '0;
        else       mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    end

    assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
    assign shift_next = {shift_q[WORD_BITS-2:0], mosi_s};

    // Frame decoder state register
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tx_q        <= '0;
            miso_q      <= 1'b0;
            idx_q       <= '0;
            last_cmd_q  <= 8'h00;
            xfer_done_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            load_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            idx_q       <= idx_d;
            last_cmd_q  <= last_cmd_d;
            xfer_done_q <= xfer_done_d;
            cmd_err_q   <= cmd_err_d;
            load_q      <= mem_re;
        end
    end

    // Next-state logic: bit counting, opcode/address decode, data shifting
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        miso_d      = 1'b0;
        idx_d       = idx_q;
        last_cmd_d  = last_cmd_q;
        xfer_done_d = 1'b0;
        cmd_err_d   = 1'b0;
        mem_re      = 1'b0;
        mem_ridx    = idx_q;
        mem_we      = 1'b0;

        // The word read one CLK earlier lands in the transmit register here;
        // this always precedes the next falling spi_clk edge.
        if (load_q) tx_d = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d   = ST_CMD;
                    bit_cnt_d = '0;
                end
            end
            ST_CMD: begin
                if (sclk_rise) begin
                    shift_d   = shift_next;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == CMD_LAST) begin
                        bit_cnt_d  = '0;
                        last_cmd_d = shift_next[7:0];
                        if (opc_supported(shift_next[7:0])) begin
                            state_d = ST_ADDR;
                        end else begin
                            cmd_err_d = 1'b1;
                            state_d   = ST_IGNORE;
                        end
                    end
                end
            end
            ST_ADDR: begin
                if (sclk_rise) begin
                    shift_d   = shift_next;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == ADDR_LAST) begin
                        bit_cnt_d = '0;
                        idx_d     = shift_next[IDX_W+1:2];
                        if (last_cmd_q == OPC_READ) begin
                            mem_re   = 1'b1;
                            mem_ridx = shift_next[IDX_W+1:2];
                            state_d  = ST_RD_DATA;
                        end else begin
                            state_d = ST_WR_DATA;
                        end
                    end
                end
            end
            ST_RD_DATA: begin
                miso_d = miso_q;
                if (sclk_fall) begin
                    miso_d = tx_q[WORD_BITS-1];
                    tx_d   = {tx_q[WORD_BITS-2:0], 1'b0};
                end
                if (sclk_rise) begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == WORD_LAST) begin
                        bit_cnt_d   = '0;
                        xfer_done_d = 1'b1;
                        idx_d       = idx_q + IDX_W'(1);
                        mem_re      = 1'b1;
                        mem_ridx    = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_WR_DATA: begin
                if (sclk_rise) begin
                    shift_d   = shift_next;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == WORD_LAST) begin
                        bit_cnt_d   = '0;
                        mem_we      = 1'b1;
                        xfer_done_d = 1'b1;
                        idx_d       = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_IGNORE: begin
                miso_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // End of frame wins over state but not over a word completing in the
        // same CLK: that word's commit above still happens.
        if (state_q != ST_IDLE && cs_rise) begin
            state_d   = ST_IDLE;
            miso_d    = 1'b0;
            bit_cnt_d = '0;
        end
    end

    // Storage write port: a full word at the current index
    always_ff @(posedge CLK) begin
        if (mem_we) mem[idx_q] <= shift_next;
    end

    // Storage read port: one CLK synchronous latency
    always_ff @(posedge CLK) begin
        if (mem_re) rdata_q <= mem[mem_ridx];
    end

    assign spi_miso    = miso_q;
    assign xfer_done   = xfer_done_q;
    assign cmd_err     = cmd_err_q;
    assign last_cmd    = last_cmd_q;
    assign dbg_state_o = state_q;

endmodule
